// File: rtl/divider_pkg.sv
// Types and defaults shared by the multdiv iterative units (divider and multiplier).
package divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;
  localparam int DIV_WIDTH = 32;
endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: out = neg ? -in : in.
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);
  assign out_o = neg_i ? (-in_i) : in_i;
endmodule

// File: rtl/restoring_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, signed or unsigned operands,
// divide-by-zero flag, one-cycle completion pulse.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_x_q, sign_x_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             exc_q, exc_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]   sh, diff;
  logic             no_borrow;

  assign a_neg = ctrl_signed & data_operandA[WIDTH-1];
  assign b_neg = ctrl_signed & data_operandB[WIDTH-1];

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (.in_i(data_operandA), .neg_i(a_neg),    .out_o(a_mag));
  cond_negate #(.WIDTH(WIDTH)) u_neg_b (.in_i(data_operandB), .neg_i(b_neg),    .out_o(b_mag));
  cond_negate #(.WIDTH(WIDTH)) u_neg_q (.in_i(dvd_q),         .neg_i(sign_x_q), .out_o(q_fix));
  cond_negate #(.WIDTH(WIDTH)) u_neg_r (.in_i(rem_q),         .neg_i(sign_a_q), .out_o(r_fix));

  // The shifted partial remainder is below 2*divisor, so a set top bit already means no borrow.
  assign sh        = {rem_q, dvd_q[WIDTH-1]};
  assign diff      = sh - {1'b0, dvs_q};
  assign no_borrow = sh[WIDTH] | ~diff[WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    sign_a_d    = sign_a_q;
    sign_x_d    = sign_x_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exc_d       = exc_q;

    unique case (state_q)
      RUN: begin
        rem_d = no_borrow ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        result_d    = q_fix;
        remainder_d = r_fix;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start in any state wins, aborting whatever was in flight.
    if (ctrl_DIV) begin
      sign_a_d = a_neg;
      sign_x_d = a_neg ^ b_neg;
      dvd_d    = a_mag;
      dvs_d    = b_mag;
      rem_d    = '0;
      cnt_d    = CW'(WIDTH);
      exc_d    = 1'b0;
      state_d  = RUN;
      if (data_operandB == '0) begin
        cnt_d       = '0;
        exc_d       = 1'b1;
        result_d    = '1;
        remainder_d = data_operandA;
        state_d     = DONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_x_q    <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      sign_a_q    <= sign_a_d;
      sign_x_q    <= sign_x_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exc_q       <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_remainder = remainder_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: 32-bit scoreboarded vector table plus
// abort/reset sequences, and a short 8-bit table.
module tb_restoring_divider;
  logic        clock, reset;
  logic [31:0] opa32, opb32, res32, rem32;
  logic        div32, sgn32, exc32, rdy32, busy32;
  logic [7:0]  opa8, opb8, res8, rem8;
  logic        div8, sgn8, exc8, rdy8, busy8;

  int tests = 0;
  int fails = 0;

  restoring_divider #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset),
    .data_operandA(opa32), .data_operandB(opb32),
    .ctrl_DIV(div32), .ctrl_signed(sgn32),
    .data_result(res32), .data_remainder(rem32),
    .data_exception(exc32), .data_resultRDY(rdy32), .busy(busy32)
  );

  restoring_divider #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset),
    .data_operandA(opa8), .data_operandB(opb8),
    .ctrl_DIV(div8), .ctrl_signed(sgn8),
    .data_result(res8), .data_remainder(rem8),
    .data_exception(exc8), .data_resultRDY(rdy8), .busy(busy8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] q, r;
    logic        e;
  } vec_t;

  typedef struct {
    logic [31:0] q, r;
    logic        e;
  } exp_t;

  typedef struct {
    logic [7:0] a, b;
    logic       s;
    logic [7:0] q, r;
    logic       e;
    int         lat;
  } vec8_t;

  exp_t  sb[$];
  vec_t  vecs[13];
  vec8_t vecs8[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rdy32) begin
      if (sb.size() == 0) begin
        chk("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", res32, e.q);
        chk("remainder", rem32, e.r);
        chk("exception", {31'd0, exc32}, {31'd0, e.e});
      end
    end
  end

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit push, input logic [31:0] q, input logic [31:0] r,
                         input logic e);
    exp_t x;
    opa32 = a; opb32 = b; sgn32 = s; div32 = 1'b1;
    if (push) begin
      x.q = q; x.r = r; x.e = e;
      sb.push_back(x);
    end
    @(posedge clock); #1;
    div32 = 1'b0;
  endtask

  task automatic wait_rdy32(output int n, output bit busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (!rdy32 && n < 60) begin
      if (!busy32) busy_ok = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    if (!busy32) busy_ok = 1'b0;
  endtask

  int  lat;
  bit  bok;

  initial begin
    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    vecs[2]  = '{32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,   32'd2,          1'b0};
    vecs[3]  = '{32'd55,         32'd0,          1'b0, 32'hFFFFFFFF,   32'd55,         1'b1};
    vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0};
    vecs[5]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[6]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[7]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0};
    vecs[8]  = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0};
    vecs[9]  = '{32'hFFFFFFC9,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFC9,   1'b1};
    vecs[10] = '{32'h80000000,   32'd2,          1'b0, 32'h40000000,   32'd0,          1'b0};
    vecs[11] = '{32'h80000000,   32'd3,          1'b1, 32'hD5555556,   32'hFFFFFFFE,   1'b0};
    vecs[12] = '{32'd7,          32'hFFFFFFFE,   1'b0, 32'd0,          32'd7,          1'b0};

    vecs8[0] = '{8'd200, 8'd3,   1'b0, 8'd66,  8'd2,   1'b0, 10};
    vecs8[1] = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'd0,   1'b0, 10};
    vecs8[2] = '{8'hF9,  8'd2,   1'b1, 8'hFD,  8'hFF,  1'b0, 10};
    vecs8[3] = '{8'd9,   8'd0,   1'b0, 8'hFF,  8'd9,   1'b1, 1};

    // Reset with a simultaneous start strobe that must be ignored.
    reset = 1'b1;
    opa32 = 32'd100; opb32 = 32'd5; sgn32 = 1'b0; div32 = 1'b1;
    opa8 = 8'd0; opb8 = 8'd0; sgn8 = 1'b0; div8 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; div32 = 1'b0;
    chk("rst_result", res32, 32'd0);
    chk("rst_remainder", rem32, 32'd0);
    chk("rst_exception", {31'd0, exc32}, 32'd0);
    chk("rst_rdy", {31'd0, rdy32}, 32'd0);
    chk("rst_busy", {31'd0, busy32}, 32'd0);
    @(posedge clock); #1;
    chk("rst_start_ignored", {31'd0, busy32}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      start32(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, vecs[i].q, vecs[i].r, vecs[i].e);
      wait_rdy32(lat, bok);
      chk($sformatf("rdy_seen_%0d", i), {31'd0, rdy32}, 32'd1);
      chk($sformatf("latency_%0d", i), lat, (vecs[i].b == 32'd0) ? 32'd1 : 32'd34);
      chk($sformatf("busy_%0d", i), {31'd0, bok}, 32'd1);
    end
    @(posedge clock); #1;
    chk("idle_busy", {31'd0, busy32}, 32'd0);
    chk("idle_rdy", {31'd0, rdy32}, 32'd0);

    // Abort: 7/2 is replaced at RUN cycle 10 by 9/4; only the latter completes.
    start32(32'd7, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (9) begin @(posedge clock); #1; end
    chk("abort_busy", {31'd0, busy32}, 32'd1);
    start32(32'd9, 32'd4, 1'b0, 1'b1, 32'd2, 32'd1, 1'b0);
    wait_rdy32(lat, bok);
    chk("abort_latency", lat, 32'd34);
    repeat (3) begin @(posedge clock); #1; end

    // Reset mid-RUN with a start strobe held during reset.
    start32(32'd1000, 32'd9, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (5) begin @(posedge clock); #1; end
    reset = 1'b1; div32 = 1'b1; opb32 = 32'd3;
    @(posedge clock); #1;
    reset = 1'b0; div32 = 1'b0;
    chk("midrst_result", res32, 32'd0);
    chk("midrst_remainder", rem32, 32'd0);
    chk("midrst_busy", {31'd0, busy32}, 32'd0);
    chk("midrst_rdy", {31'd0, rdy32}, 32'd0);
    repeat (40) begin @(posedge clock); #1; end
    chk("midrst_still_idle", {31'd0, busy32}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      int n;
      opa8 = vecs8[i].a; opb8 = vecs8[i].b; sgn8 = vecs8[i].s; div8 = 1'b1;
      @(posedge clock); #1;
      div8 = 1'b0;
      n = 1;
      while (!rdy8 && n < 30) begin @(posedge clock); #1; n++; end
      chk($sformatf("w8_rdy_%0d", i), {31'd0, rdy8}, 32'd1);
      chk($sformatf("w8_latency_%0d", i), n, vecs8[i].lat);
      chk($sformatf("w8_result_%0d", i), {24'd0, res8}, {24'd0, vecs8[i].q});
      chk($sformatf("w8_remainder_%0d", i), {24'd0, rem8}, {24'd0, vecs8[i].r});
      chk($sformatf("w8_exception_%0d", i), {31'd0, exc8}, {31'd0, vecs8[i].e});
      @(posedge clock); #1;
      chk($sformatf("w8_pulse_%0d", i), {31'd0, rdy8}, 32'd0);
    end

    repeat (3) begin @(posedge clock); #1; end
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
